ayatsuki_soc_top: RTL and testbench

UART echo subsystem at the top of the AyaTsuki SoC, clocked at 50 MHz.
- A serial receiver deserialises 8N1 frames from uart_rx into a small RX FIFO.
- A transmitter drains the FIFO and re-sends each byte on uart_tx.
- Its role is the board-level serial bring-up path: every byte received is echoed unchanged, in order.

---
 rtl/ayatsuki_soc_top.sv | 131 +++++++++++++
 tb/tb_ayatsuki_soc_top.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ayatsuki_soc_top.sv
// ayatsuki_soc_top: 8N1 UART echo, RX deserialiser -> small FIFO -> TX serialiser
module ayatsuki_soc_top #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t rx_state, tx_state;
  logic rx_meta, rxs, rx_err, push, pop, wr_en;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_shift, tx_shift;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  // synchronise the async line; reset to idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) {rx_meta, rxs} <= 2'b11;
    else {rx_meta, rxs} <= {uart_rx, rx_meta};
  end
  // a valid stop-bit centre delivers a byte; TX takes one whenever it is idle; full FIFO drops
  always_comb begin
    push = rx_state == STOP && !rx_err && rx_cnt == BIT_LAST && rxs;
    pop = tx_state == IDLE && count != '0;
    wr_en = push && count != FULL;
  end
  // receiver: qualify start at half a bit, then sample each bit centre, LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
      rx_err <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_err <= 1'b0;
          if (!rxs) rx_state <= START;
        end
        START: begin
          rx_cnt <= rx_cnt == HALF_LAST ? '0 : rx_cnt + CW'(1);
          if (rx_cnt == HALF_LAST) rx_state <= rxs ? IDLE : DATA;
        end
        DATA: begin
          rx_cnt <= rx_cnt == BIT_LAST ? '0 : rx_cnt + CW'(1);
          if (rx_cnt == BIT_LAST) begin
            rx_shift <= {rxs, rx_shift[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= STOP;
          end
        end
        STOP: begin
          if (rx_err || rx_cnt == BIT_LAST) begin
            rx_state <= rxs ? IDLE : STOP;
            rx_err <= !rxs;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
      endcase
    end
  end
  // RX FIFO: pointers wrap naturally, simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end
  end
  // transmitter: line level registered per state, so a popped byte starts one clock later
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          uart_tx <= 1'b1;
          tx_cnt <= '0;
          tx_bit <= '0;
          if (pop) begin
            tx_shift <= mem[rd_ptr];
            tx_state <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          tx_cnt <= tx_cnt == BIT_LAST ? '0 : tx_cnt + CW'(1);
          if (tx_cnt == BIT_LAST) tx_state <= DATA;
        end
        DATA: begin
          uart_tx <= tx_shift[0];
          tx_cnt <= tx_cnt == BIT_LAST ? '0 : tx_cnt + CW'(1);
          if (tx_cnt == BIT_LAST) begin
            tx_shift <= tx_shift >> 1;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= STOP;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          tx_cnt <= tx_cnt == BIT_LAST ? '0 : tx_cnt + CW'(1);
          if (tx_cnt == BIT_LAST) tx_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ayatsuki_soc_top.sv
// tb_ayatsuki_soc_top: directed echo bench with a frame-level line model
module tb_ayatsuki_soc_top;
  localparam int CPB = 434;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  int starts[$];
  logic [7:0] expq[$];
  logic [7:0] got[$];
  ayatsuki_soc_top dut (.clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit good);
    if (good) expq.push_back(b);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = good;
    tick(CPB);
  endtask
  task automatic wait_done(input int n, input int limit);
    int k;
    k = 0;
    while (done_n < n && k < limit) begin
      tick(1);
      k++;
    end
    check("frames_completed", done_n, n);
  endtask
  task automatic run_frame(input logic [7:0] e, input bit known);
    logic [9:0] bits;
    logic [7:0] d;
    int bad;
    bits = {1'b1, e, 1'b0};
    d = '0;
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (rst) return;
        if (uart_tx !== bits[i]) bad++;
        if (c == CPB / 2 && i >= 1 && i <= 8) d[i-1] = uart_tx;
      end
      if (known) check($sformatf("tx_slot%0d_bad_clocks", i), bad, 0);
    end
    got.push_back(d);
    done_n++;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) expq.delete();
    else if (uart_tx === 1'b0) begin
      starts.push_back(cyc);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame at cycle %0d got start bit expected idle line", cyc);
        run_frame(8'h00, 1'b0);
      end else run_frame(expq.pop_front(), 1'b1);
    end
  end
  initial begin
    int t0, n, bad, k, sp;
    bad = 0;
    tick(1);
    for (int i = 0; i < 1009; i++) begin
      if (i == 9) rst = 1'b0;
      if (uart_tx !== 1'b1) bad++;
      tick(1);
    end
    check("reset_idle_violations", bad, 0);
    check("reset_frames", starts.size(), 0);
    t0 = cyc;
    send_frame(8'h55, 1'b1);
    wait_done(1, 6000);
    check("latency_0x55", starts[0] - t0, 4128);
    check("byte_0x55", got[0], 8'h55);
    tick(200);
    uart_rx = 1'b0;
    tick(100);
    uart_rx = 1'b1;
    tick(5000);
    check("glitch_frames", starts.size(), 1);
    send_frame(8'hA3, 1'b0);
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
    send_frame(8'h3C, 1'b1);
    wait_done(2, 6000);
    check("framing_frames", starts.size(), 2);
    check("framing_byte", got[1], 8'h3C);
    tick(200);
    n = starts.size();
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_done(5, 15000);
    check("burst_byte0", got[2], 8'h01);
    check("burst_byte1", got[3], 8'h80);
    check("burst_byte2", got[4], 8'hFF);
    for (int i = 1; i < 3; i++) begin
      sp = starts[n+i] - starts[n+i-1];
      checks++;
      if (sp < 10 * CPB || sp > 10 * CPB + 1) begin
        errors++;
        $display("FAIL burst_spacing%0d got %0d clocks expected 4340 or 4341", i, sp);
      end
    end
    tick(200);
    send_frame(8'h55, 1'b1);
    k = 0;
    while (starts.size() < 6 && k < 10000) begin
      tick(1);
      k++;
    end
    check("rst_echo_started", starts.size(), 6);
    t0 = starts[5];
    while (cyc < t0 + 5 * CPB + CPB / 2) tick(1);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < CPB + 10; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) bad++;
    end
    check("rst_tx_low_clocks", bad, 0);
    rst = 1'b0;
    tick(5000);
    check("rst_no_more_frames", starts.size(), 6);
    check("rst_completed_frames", done_n, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
